// File: rtl/sram_ctrl64.sv
// sram_ctrl64: bridge from the MEM pipeline stage to a 64-bit-read /
// 32-bit-write SRAM. One request is handled at a time. The bus is held
// for WAIT_CYCLES cycles, then ready pulses high for a single DONE cycle.
//
// Ports:
//   clk, rst        system clock; asynchronous active-high reset
//   wr_en, rd_en    MEM-stage requests, held until ready (write wins)
//   addr, wdata     byte address (word aligned) and store data
//   rdata           selected 32-bit word of the last completed read
//   rdata64         {odd word, even word} of the last completed read
//   ready           low while a request is outstanding (pipeline freeze)
//   SRAM_WE_N       SRAM write enable, active low
//   SRAM_ADDR       SRAM word address
//   SRAM_DQ         SRAM data bus, driven only during a write access
module sram_ctrl64 #(
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [63:0] rdata64,
  output logic        ready,
  output logic        SRAM_WE_N,
  output logic [16:0] SRAM_ADDR,
  inout  wire  [63:0] SRAM_DQ
);

  // Counter must reach WAIT_CYCLES (its value in DONE); never narrower than 3.
  localparam int CW = ($clog2(WAIT_CYCLES + 1) < 3) ? 3 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            is_wr_q;
  logic [16:0]     idx_q;
  logic [31:0]     wdata_q;
  logic            dq_oe;
  logic [16:0]     idx_in;

  // Offset from the SRAM base wraps mod 2^32; only bits [18:2] select a word.
  assign idx_in = 17'((addr - ADDR_BASE) >> 2);

  // IDLE answers the request combinationally so the pipeline freezes in the
  // very cycle the request appears; reset forces IDLE, so the same holds then.
  assign ready = (state == IDLE) ? ~(wr_en | rd_en) : (state == DONE);

  // Only the lower half carries write data; the upper half is zero-filled.
  assign SRAM_DQ = dq_oe ? {32'b0, wdata_q} : 64'bz;

  // NOTE: every register here, including the read-data outputs, is cleared by
  // the asynchronous reset so the bus is released the instant rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      is_wr_q   <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      dq_oe     <= 1'b0;
      SRAM_WE_N <= 1'b1;
      SRAM_ADDR <= '0;
      rdata     <= '0;
      rdata64   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (wr_en | rd_en) begin
            state     <= BUSY;
            cnt       <= '0;
            is_wr_q   <= wr_en;
            idx_q     <= idx_in;
            wdata_q   <= wdata;
            SRAM_ADDR <= idx_in;
            // Write strobe is low only for the first BUSY cycle (cnt==0).
            SRAM_WE_N <= ~wr_en;
            dq_oe     <= wr_en;
          end
        end
        BUSY: begin
          cnt       <= cnt + 1'b1;
          SRAM_WE_N <= 1'b1;
          if (cnt == CNT_LAST) begin
            state     <= DONE;
            dq_oe     <= 1'b0;
            SRAM_ADDR <= '0;
            if (!is_wr_q) begin
              // The selected word is captured with the pair, so a later write
              // to a different word parity cannot change rdata.
              rdata64 <= SRAM_DQ;
              rdata   <= idx_q[0] ? SRAM_DQ[63:32] : SRAM_DQ[31:0];
            end
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          dq_oe     <= 1'b0;
          SRAM_WE_N <= 1'b1;
          SRAM_ADDR <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl64.sv
// tb_sram_ctrl64: directed bench for sram_ctrl64 with a small SRAM model.
// Read expectations are queued when a read is issued and compared when the
// controller reports DONE.
module tb_sram_ctrl64;

  localparam int WAIT = 5;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [63:0] rdata64;
  logic        ready;
  logic        sram_we_n;
  logic [16:0] sram_addr;
  wire  [63:0] sram_dq;

  sram_ctrl64 #(.ADDR_BASE(32'd1024), .WAIT_CYCLES(WAIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .rdata64  (rdata64),
    .ready    (ready),
    .SRAM_WE_N(sram_we_n),
    .SRAM_ADDR(sram_addr),
    .SRAM_DQ  (sram_dq)
  );

  // SRAM model: 16 words (low address bits only), 32-bit write on WE_N low,
  // 64-bit even/odd pair read driven while the bench marks a read phase.
  logic [31:0] mem [0:15];
  logic        rd_phase;
  logic [3:0]  m_even;
  logic [63:0] model_word;

  assign m_even     = {sram_addr[3:1], 1'b0};
  assign model_word = {mem[m_even | 4'd1], mem[m_even]};
  assign sram_dq    = (rd_phase && sram_we_n) ? model_word : 64'bz;

  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr[3:0]] <= sram_dq[31:0];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pair;
    logic [31:0] word;
  } sb_t;

  sb_t         sb [$];
  logic [31:0] exp_mem [0:15];
  int          total  = 0;
  int          passed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One access: request driven at a falling edge (cycle 0), then per-cycle
  // observation until ready, bounded by a cycle budget.
  task automatic access(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                        input bit hold, input logic [16:0] exp_idx);
    int          lat;
    int          we_cyc;
    logic [16:0] busy_addr;
    bit          dq_bad;
    sb_t         e;
    logic [3:0]  m;
    logic [3:0]  me;
    m  = exp_idx[3:0];
    me = {m[3:1], 1'b0};
    e  = '0;
    @(negedge clk);
    wr_en = w; rd_en = r; addr = a; wdata = d;
    rd_phase = r & ~w;
    if (w) exp_mem[m] = d;
    else begin
      e.pair = {exp_mem[me | 4'd1], exp_mem[me]};
      e.word = exp_idx[0] ? exp_mem[me | 4'd1] : exp_mem[me];
      sb.push_back(e);
    end
    #2;
    check("ready_cycle0", {63'b0, ready}, 64'd0);
    lat = 0; we_cyc = 0; busy_addr = '0; dq_bad = 1'b0;
    while (ready !== 1'b1 && lat < 20) begin
      @(negedge clk);
      #2;
      lat++;
      if (ready !== 1'b1) begin
        if (lat == 1) busy_addr = sram_addr;
        if (sram_we_n === 1'b0) we_cyc++;
        if (w && sram_dq !== {32'b0, d}) dq_bad = 1'b1;
        if (!w && sram_dq !== e.pair) dq_bad = 1'b1;
      end
    end
    check("latency", 64'(lat), 64'(WAIT + 1));
    check("busy_addr", {47'b0, busy_addr}, {47'b0, exp_idx});
    check("we_cycles", 64'(we_cyc), w ? 64'd1 : 64'd0);
    check("dq_bus", {63'b0, dq_bad}, 64'd0);
    if (!w) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rdata64", rdata64, e.pair);
        check("rdata", {32'b0, rdata}, {32'b0, e.word});
      end else begin
        check("scoreboard_empty", 64'd1, 64'd0);
      end
    end
    if (!hold) begin
      wr_en = 1'b0; rd_en = 1'b0; rd_phase = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0; rd_phase = 1'b0;
    #2;
    check("rst_we_n", {63'b0, sram_we_n}, 64'd1);
    check("rst_addr", {47'b0, sram_addr}, 64'd0);
    check("rst_rdata", {32'b0, rdata}, 64'd0);
    check("rst_rdata64", rdata64, 64'd0);
    check("rst_ready", {63'b0, ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // 1. write word 0
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, 17'd0);
    @(negedge clk);
    check("mem0", {32'b0, mem[0]}, {32'b0, 32'hDEADBEEF});
    check("idle_we_n", {63'b0, sram_we_n}, 64'd1);
    check("idle_ready", {63'b0, ready}, 64'd1);

    // 2. write word 1 then read it back (odd word selected)
    access(1'b1, 1'b0, 32'd1028, 32'd7, 1'b0, 17'd1);
    access(1'b0, 1'b1, 32'd1028, 32'd0, 1'b0, 17'd1);

    // extra words for later reads of the pair (2,3)
    access(1'b1, 1'b0, 32'd1036, 32'h33333333, 1'b0, 17'd3);

    // 3. read word 0 (even word selected)
    access(1'b0, 1'b1, 32'd1024, 32'd0, 1'b0, 17'd0);

    // 4. both requests high: treated as a write, read data untouched
    access(1'b1, 1'b1, 32'd1032, 32'd5, 1'b0, 17'd2);
    @(negedge clk);
    check("mem2", {32'b0, mem[2]}, 64'd5);
    check("rdata_after_wr", {32'b0, rdata}, {32'b0, 32'hDEADBEEF});
    check("rdata64_after_wr", rdata64, {32'd7, 32'hDEADBEEF});

    // 5. back-to-back reads: request held through DONE
    access(1'b0, 1'b1, 32'd1028, 32'd0, 1'b1, 17'd1);
    access(1'b0, 1'b1, 32'd1024, 32'd0, 1'b0, 17'd0);

    // address boundaries: below base wraps, bits above 18 ignored
    access(1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 17'h1FF00);
    access(1'b0, 1'b1, 32'h0008_0408, 32'd0, 1'b0, 17'd2);

    // 6. reset during BUSY of a read (cnt == 2), result discarded
    @(negedge clk);
    rd_en = 1'b1; addr = 32'd1028; rd_phase = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_we_n", {63'b0, sram_we_n}, 64'd1);
    check("midrst_rdata", {32'b0, rdata}, 64'd0);
    check("midrst_rdata64", rdata64, 64'd0);
    check("midrst_addr", {47'b0, sram_addr}, 64'd0);
    check("midrst_ready_req", {63'b0, ready}, 64'd0);
    rd_en = 1'b0; rd_phase = 1'b0;
    #1;
    check("midrst_ready_noreq", {63'b0, ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("post_rst_ready", {63'b0, ready}, 64'd1);
    rd_en = 1'b1;
    #1;
    check("post_rst_ready_req", {63'b0, ready}, 64'd0);
    rd_en = 1'b0;
    #1;
    check("post_rst_rdata", {32'b0, rdata}, 64'd0);

    // recovery read after reset
    access(1'b0, 1'b1, 32'd1024, 32'd0, 1'b0, 17'd0);

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
